// File: rtl/divider_unit_if.sv
// Request/response bundle between the M-extension controller and the divider.
interface divider_unit_if #(
    parameter int XLEN = 32
);
    logic            div_valid;
    logic [1:0]      DIVop;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] div_result;
    logic            div_ready;
    logic            div_busy;

    modport master (
        output div_valid, DIVop, dividend, divisor,
        input  div_result, div_ready, div_busy
    );

    modport slave (
        input  div_valid, DIVop, dividend, divisor,
        output div_result, div_ready, div_busy
    );
endinterface

// File: rtl/divider_unit.sv
// RV32M DIV/DIVU/REM/REMU engine: radix-2 restoring division, one quotient bit
// per clock, with single-cycle fast paths for divide-by-zero and signed overflow.
module divider_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          resetn,
    divider_unit_if.slave bus
);
    localparam logic [1:0] DIV_OP_DIV = 2'd0;
    localparam logic [1:0] DIV_OP_REM = 2'd2;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_signed;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] quot_nx, rem_nx;

    always_comb begin
        is_signed = (bus.DIVop == DIV_OP_DIV) || (bus.DIVop == DIV_OP_REM);
        abs_a = (is_signed && bus.dividend[XLEN-1]) ? ('0 - bus.dividend) : bus.dividend;
        abs_b = (is_signed && bus.divisor[XLEN-1])  ? ('0 - bus.divisor)  : bus.divisor;

        // Partial remainder is below the divisor, so the shifted value needs one extra bit.
        shifted = {rem_q, quot_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_nx  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quot_nx = {quot_q[XLEN-2:0], ~diff[XLEN]};
    end

    always_comb begin
        state_d    = state_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (bus.div_valid) begin
                    is_rem_d   = bus.DIVop[1];
                    neg_quot_d = is_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                    neg_rem_d  = is_signed && bus.dividend[XLEN-1];
                    quot_d     = abs_a;
                    dvs_d      = abs_b;
                    rem_d      = '0;
                    cnt_d      = 5'd31;
                    if (bus.divisor == '0) begin
                        result_d = bus.DIVop[1] ? bus.dividend : '1;
                        state_d  = DONE;
                    end else if (is_signed && bus.dividend == MIN_NEG && bus.divisor == '1) begin
                        result_d = bus.DIVop[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                quot_d = quot_nx;
                rem_d  = rem_nx;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    if (is_rem_q) result_d = neg_rem_q  ? ('0 - rem_nx)  : rem_nx;
                    else          result_d = neg_quot_q ? ('0 - quot_nx) : quot_nx;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

    assign bus.div_result = result_q;
    assign bus.div_ready  = (state_q == DONE);
    assign bus.div_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_divider_unit.sv
// Directed-vector bench for divider_unit with hand-computed quotients/remainders.
module tb_divider_unit;
    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    divider_unit_if #(.XLEN(32)) bus ();

    divider_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request for a single cycle, then measures edges from acceptance to div_ready.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input bit toggle);
        int lat;
        @(negedge clk);
        bus.DIVop = op; bus.dividend = a; bus.divisor = b; bus.div_valid = 1'b1;
        @(posedge clk); #1;
        bus.div_valid = 1'b0;
        lat = 1;
        check({tag, "_busy"}, {31'd0, bus.div_busy}, 32'd1);
        while (bus.div_ready !== 1'b1 && lat < 60) begin
            if (toggle) begin
                bus.dividend = $urandom; bus.divisor = $urandom;
                bus.DIVop = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.div_result, exp);
        @(posedge clk); #1;
        check({tag, "_rdy_off"}, {31'd0, bus.div_ready}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.div_busy}, 32'd0);
        check({tag, "_hold"}, bus.div_result, exp);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_errors = 0;
        bus.div_valid = 1'b0; bus.DIVop = OP_DIV; bus.dividend = '0; bus.divisor = '0;
        resetn = 1'b0;
        #12;
        check("rst_res",   bus.div_result, 32'd0);
        check("rst_ready", {31'd0, bus.div_ready}, 32'd0);
        check("rst_busy",  {31'd0, bus.div_busy}, 32'd0);
        @(negedge clk); resetn = 1'b1;

        do_op("div_100_7",  OP_DIV,  32'd100, 32'd7, 32'd14, 33, 1'b0);
        do_op("rem_100_7",  OP_REM,  32'd100, 32'd7, 32'd2,  33, 1'b0);
        do_op("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b0);
        do_op("rem_m7_2",   OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b0);
        do_op("divu_big_2", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33, 1'b0);
        do_op("remu_big_2", OP_REMU, 32'hFFFFFFF9, 32'd2, 32'd1,        33, 1'b0);
        do_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFFFFFE, 32'd1,        33, 1'b0);
        do_op("div_min_2",  OP_DIV,  32'h80000000, 32'd2, 32'hC0000000, 33, 1'b0);

        do_op("divu_by0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        do_op("div_by0",    OP_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        do_op("rem_by0",    OP_REM,  32'd5, 32'd0, 32'd5,        1, 1'b0);
        do_op("remu_by0",   OP_REMU, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1, 1'b0);

        do_op("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
        do_op("rem_ovf",    OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1'b0);
        do_op("divu_ovf",   OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, 1'b0);

        do_op("div_toggle", OP_DIV,  32'd1000, 32'hFFFFFFF6, 32'hFFFFFF9C, 33, 1'b1);

        // Reset in the middle of CALC.
        @(negedge clk);
        bus.DIVop = OP_DIV; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.div_valid = 1'b1;
        @(posedge clk); #1;
        bus.div_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("mid_busy", {31'd0, bus.div_busy}, 32'd1);
        check("mid_hold", bus.div_result, 32'hFFFFFF9C);
        resetn = 1'b0;
        #1;
        check("arst_busy",  {31'd0, bus.div_busy}, 32'd0);
        check("arst_ready", {31'd0, bus.div_ready}, 32'd0);
        check("arst_res",   bus.div_result, 32'd0);
        @(negedge clk); resetn = 1'b1;
        do_op("div_post_rst", OP_DIV, 32'd100, 32'd7, 32'd14, 33, 1'b0);

        // div_valid held through DONE re-issues in the following IDLE cycle.
        @(negedge clk);
        bus.DIVop = OP_DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.div_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (bus.div_ready !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        check("b2b_lat1", 32'(lat), 32'd33);
        check("b2b_res1", bus.div_result, 32'd14);
        bus.DIVop = OP_REMU;
        @(posedge clk); #1;
        check("b2b_gap", {31'd0, bus.div_busy}, 32'd0);
        @(posedge clk); #1;
        bus.div_valid = 1'b0;
        check("b2b_accept", {31'd0, bus.div_busy}, 32'd1);
        lat = 1;
        while (bus.div_ready !== 1'b1 && lat < 60) begin
            if (lat == 20) check("b2b_stable", bus.div_result, 32'd14);
            @(posedge clk); #1; lat++;
        end
        check("b2b_lat2", 32'(lat), 32'd33);
        check("b2b_res2", bus.div_result, 32'd2);
        @(posedge clk); #1;
        check("b2b_end", {31'd0, bus.div_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Multi-cycle RV32M division/remainder engine for the multicycle core.
- Consumes the decoded `DIVop` and `div_valid` from the M-extension decode path, plus rs1 and rs2 operands.
- Returns a registered 32-bit result with a one-cycle `div_ready` completion strobe.
- Uses a radix-2 restoring algorithm (one quotient bit per clock), with fast paths for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- div_valid  input  1  request; sampled only in IDLE.
- DIVop  input  `DIV_OP_WIDTH` (2)  operation: `DIV_OP_DIV`=0, `DIV_OP_DIVU`=1, `DIV_OP_REM`=2, `DIV_OP_REMU`=3.
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- div_result  output  XLEN  quotient or remainder per latched op.
- div_ready  output  1  one-cycle completion strobe.
- div_busy  output  1  high while not IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `resetn`).
- Reset values: state=IDLE, div_result=0, div_ready=0, div_busy=0; all internal registers 0.
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - If div_valid=1, latch DIVop, dividend and divisor.
  - Compute signed = (op==DIV or op==REM).
  - Take the absolute values of the operands if signed.
  - If divisor==0 or (signed and dividend==0x80000000 and divisor==0xFFFFFFFF), load the special result and go to DONE.
  - Otherwise clear the remainder, set the iteration counter to 31, and go to CALC.
  - If div_valid=0, stay in IDLE.
- CALC, one iteration per clock:
  - Shift {rem, quot} left by 1, bringing in the next dividend MSB.
  - Trial-subtract the divisor magnitude using a 33-bit subtract.
  - If non-negative, keep the difference and set quotient bit 1; else restore and set quotient bit 0.
  - After the counter==0 iteration, go to DONE.
  - Exactly 32 CALC cycles.
- DONE:
  - div_ready=1 for exactly this one cycle; div_result is valid in this cycle.
  - Unconditionally return to IDLE next edge.
- Latency, acceptance edge to div_ready high:
  - Normal: 33 clocks.
  - Special cases: 1 clock.
- Sign fix-up, applied when writing div_result at the CALC→DONE transition:
  - Signed quotient is negated iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Unsigned ops take no fix-up.
- Special results:
  - Divide-by-zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend unchanged.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- div_result holds its value after DONE until the next completion; it changes only on entry to DONE or on reset.
- Inputs are ignored outside IDLE:
  - Deasserting div_valid mid-operation does not abort.
  - Changes to DIVop or operands mid-operation are ignored.
- div_valid still high in the IDLE cycle after DONE starts a new operation. The controller must drop div_valid on div_ready to avoid re-issue.
- Reset asserted mid-CALC: immediate return to IDLE with all outputs 0; no div_ready pulse.
- An unknown DIVop cannot occur, because the decoder gates div_valid. If it does occur, treat it as DIVU (design choice, no assertion).

Test Plan:
1. DIV 100/7, div_valid held one cycle → div_busy high; div_ready pulses exactly 33 clocks after acceptance with div_result=14. Repeat as REM → 2.
2. DIV 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD(-3); REM → 0xFFFFFFFF(-1); DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1; REM 7/-2 → 1.
3. Divide-by-zero: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; div_ready 1 clock after acceptance, never entering CALC.
4. Signed overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; 1-clock latency. DIVU of the same operands → 0 via the normal 33-clock path.
5. Reset: assert resetn=0 at CALC cycle 10 → div_busy=0, div_ready=0, div_result=0 immediately. After release, DIV 100/7 completes normally with 14.
6. Back-to-back and stability:
   - div_valid held high through DONE → second operation accepted in the following IDLE cycle.
   - Operands toggled during CALC do not affect the result.
   - div_result is stable between completions.
